load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory access stage sitting directly downstream of the control unit and ALU in the single-cycle core.
- Consumes the decoded load/store selectors and the ALU-computed address, and drives a handshaked word-wide data-memory port with byte enables.
- Returns sign- or zero-extended load data to the result mux.
- Stalls the core (PC hold, regWrite gating) until the access completes.

Parameters:
- TIMEOUT, 255, max REQ cycles waiting for memAck before abort; 0 disables timeout.

Ports:
- clk  in  1  core clock, rising edge
- resetN  in  1  asynchronous active-low reset
- memRead  in  1  current instruction is a load
- memWrite  in  1  current instruction is a store
- loadSrc  in  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu; 101-111 treated as lw
- storeSrc  in  2  00 sb, 01 sh, 10 sw; 11 treated as sw
- addr  in  32  byte address from ALU
- writeData  in  32  rs2 store data
- readData  out  32  formatted load result, registered
- stall  out  1  core must hold PC and suppress regWrite
- misaligned  out  1  access rejected for alignment
- busError  out  1  one-cycle pulse on timeout abort
- memReq  out  1  memory request valid
- memWe  out  1  1 = write
- memAddr  out  32  {addr[31:2],2'b00}
- memWdata  out  32  lane-replicated store data
- memBe  out  4  byte enables; all 1 for reads
- memAck  in  1  memory completes request this cycle
- memRdata  in  32  read word, valid with memAck

Behaviour:
- Reset (async, resetN=0): state IDLE; memReq=0, memWe=0, memAddr=0, memWdata=0, memBe=0, readData=0, busError=0, timeout counter=0. Applies mid-access: an in-flight request is dropped immediately and memory must tolerate it.
- FSM states are IDLE, REQ and DONE.
- IDLE:
  - If (memRead|memWrite) and aligned: stall=1 combinationally. Register memReq=1, memWe=memWrite, memAddr, memWdata, memBe, byte offset addr[1:0] and the load format. Next state is REQ.
  - If misaligned: misaligned=1 combinationally, stall=0, no request, readData unchanged, state stays IDLE. The core retires the instruction as a no-op.
  - Misaligned means: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=00.
  - memRead and memWrite both 1: the write wins and readData is unchanged.
- REQ:
  - stall=1. memReq and all mem* outputs stay stable until memAck.
  - On memAck=1: memReq drops next cycle. For a read, readData <= formatted memRdata. Next state is DONE.
  - Counter increments each REQ cycle without ack. When it reaches TIMEOUT (TIMEOUT>0): abort, memReq=0, readData<=0, busError=1 for one cycle (the DONE cycle), next state DONE.
- DONE: stall=0 and readData valid. The core commits on this clock edge. memRead/memWrite are ignored because they still belong to the same instruction. Next state is always IDLE.
- memAck outside REQ is ignored.
- Latency: minimum 3 cycles per access (IDLE, REQ with immediate ack, DONE); every extra memory wait cycle adds 1.
- Store formatting:
  - sb: memWdata={4{wd[7:0]}}, memBe=4'b0001<<addr[1:0]
  - sh: memWdata={2{wd[15:0]}}, memBe=addr[1]?1100:0011
  - sw: memWdata=wd, memBe=1111
- Load formatting: select the byte/halfword of memRdata using the captured offset.
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
  - lw: pass through.
- Counter width is $clog2(TIMEOUT+1). It clears on entry to REQ.

Test Plan:
- Store: sb, addr=0x1003, writeData=0x000000AB, ack after 2 wait cycles -> memAddr=0x1000, memBe=1000, memWdata=0xABABABAB, memWe=1, stall high 4 cycles then low in DONE.
- lb: addr=0x2001, memRdata=0x12348056, immediate ack -> readData=0xFFFFFF80 in DONE. Same access with lbu -> readData=0x00000080. 3-cycle latency.
- lh: addr=0x2002, memRdata=0x9ABC0000 -> readData=0xFFFF9ABC. Same access with lhu -> 0x00009ABC. lw at 0x2000 -> 0x9ABC0000.
- Misaligned: lw at 0x3002 and sh at 0x3001 -> misaligned=1, stall=0, memReq never asserted, readData unchanged.
- Timeout: TIMEOUT=4, read with memAck held 0 -> memReq high exactly 4 cycles, then busError=1 for one cycle, readData=0, state back in IDLE.
- Reset mid-REQ: drive resetN low while memReq=1 -> memReq=0 and stall=0 immediately without a clock edge. After release, a new sw at 0x4000 completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage with handshaked word port, byte enables and load extension.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  loadSrc,
  input  logic [1:0]  storeSrc,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        misaligned,
  output logic        busError,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  input  logic        memAck,
  input  logic [31:0] memRdata
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_off;
  logic [2:0] r_fmt;
  logic w_lbyte, w_lhalf, w_mis, w_try, w_start, w_abort;
  logic [31:0] w_wdata, w_ldata;
  logic [3:0] w_be;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  always_comb begin
    w_lbyte = loadSrc == 3'b000 || loadSrc == 3'b011;
    w_lhalf = loadSrc == 3'b001 || loadSrc == 3'b100;
    // a simultaneous load/store is treated as the store, so its alignment rule applies
    w_mis = memWrite ? (storeSrc == 2'b00 ? 1'b0 : storeSrc == 2'b01 ? addr[0] : |addr[1:0])
                     : (w_lbyte ? 1'b0 : w_lhalf ? addr[0] : |addr[1:0]);
    w_try = resetN && r_state == IDLE && (memRead || memWrite);
    misaligned = w_try && w_mis;
    w_start = w_try && !w_mis;
    stall = w_start || r_state == REQ;
    w_wdata = storeSrc == 2'b00 ? {4{writeData[7:0]}} : storeSrc == 2'b01 ? {2{writeData[15:0]}} : writeData;
    w_be = !memWrite ? 4'b1111 : storeSrc == 2'b00 ? 4'b0001 << addr[1:0]
         : storeSrc == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_byte = memRdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? memRdata[31:16] : memRdata[15:0];
    w_ldata = r_fmt == 3'b000 ? {{24{w_byte[7]}}, w_byte}
            : r_fmt == 3'b001 ? {{16{w_half[15]}}, w_half}
            : r_fmt == 3'b011 ? {24'b0, w_byte}
            : r_fmt == 3'b100 ? {16'b0, w_half} : memRdata;
    w_abort = TIMEOUT > 0 && !memAck && 32'(r_cnt) + 32'd1 == 32'(TIMEOUT);
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_off    <= '0;
      r_fmt    <= '0;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      memBe    <= '0;
      readData <= '0;
      busError <= 1'b0;
    end else begin
      busError <= 1'b0;
      case (r_state)
        IDLE: if (w_start) begin
          memReq   <= 1'b1;
          memWe    <= memWrite;
          memAddr  <= {addr[31:2], 2'b00};
          memWdata <= w_wdata;
          memBe    <= w_be;
          r_off    <= addr[1:0];
          r_fmt    <= loadSrc;
          r_cnt    <= '0;
          r_state  <= REQ;
        end
        REQ: if (memAck) begin
          memReq  <= 1'b0;
          if (!memWe) readData <= w_ldata;
          r_state <= DONE;
        end else if (w_abort) begin
          memReq   <= 1'b0;
          readData <= '0;
          busError <= 1'b1;
          r_state  <= DONE;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random accesses checked against an arithmetic reference model.
module tb_load_store_unit;
  localparam int TO = 4;
  logic clk = 0, resetN = 0, memRead = 0, memWrite = 0, memAck = 0;
  logic [2:0] loadSrc = 0;
  logic [1:0] storeSrc = 0;
  logic [31:0] addr = 0, writeData = 0, memRdata = 0;
  logic [31:0] readData, memAddr, memWdata;
  logic stall, misaligned, busError, memReq, memWe;
  logic [3:0] memBe;
  int checks = 0, failures = 0;
  logic [31:0] exp_rd = 0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetN(resetN), .memRead(memRead), .memWrite(memWrite),
    .loadSrc(loadSrc), .storeSrc(storeSrc), .addr(addr), .writeData(writeData),
    .readData(readData), .stall(stall), .misaligned(misaligned), .busError(busError),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memBe(memBe), .memAck(memAck), .memRdata(memRdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] ls, input logic [1:0] ss,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat, input int waits);
    int size, off, reqc, exp_reqc;
    logic [31:0] e_wd, b, h, e_ld;
    logic [3:0] e_be;
    logic mis, tmo;
    off = int'(a % 4);
    if (wr) size = (ss == 0) ? 1 : (ss == 1) ? 2 : 4;
    else size = (ls == 0 || ls == 3) ? 1 : (ls == 1 || ls == 4) ? 2 : 4;
    mis = (a % size) != 0;
    b = (rdat >> (8 * off)) & 32'hFF;
    h = (rdat >> (8 * (off / 2 * 2))) & 32'hFFFF;
    case (ls)
      3'd0: e_ld = (b >= 128) ? b - 32'd256 : b;
      3'd1: e_ld = (h >= 32768) ? h - 32'd65536 : h;
      3'd3: e_ld = b;
      3'd4: e_ld = h;
      default: e_ld = rdat;
    endcase
    if (ss == 0) begin e_wd = (wd & 32'hFF) * 32'h01010101; e_be = 4'(1 << off); end
    else if (ss == 1) begin e_wd = (wd & 32'hFFFF) * 32'h00010001; e_be = (off >= 2) ? 4'd12 : 4'd3; end
    else begin e_wd = wd; e_be = 4'd15; end
    if (!wr) e_be = 4'd15;
    tmo = waits >= TO;
    exp_reqc = tmo ? TO : waits + 1;
    @(negedge clk);
    memRead = rd; memWrite = wr; loadSrc = ls; storeSrc = ss; addr = a; writeData = wd;
    memAck = 0; memRdata = $urandom;
    #1;
    chk("misaligned", 32'(misaligned), 32'(mis));
    chk("stall_idle", 32'(stall), 32'(!mis));
    if (mis) begin
      @(negedge clk);
      chk("mis_noreq", 32'(memReq), 0);
      chk("mis_readdata", readData, exp_rd);
      memRead = 0; memWrite = 0;
      return;
    end
    reqc = 0;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      if (memReq !== 1'b1) break;
      if (reqc == 0) begin
        chk("memAddr", memAddr, a & 32'hFFFFFFFC);
        chk("memBe", 32'(memBe), 32'(e_be));
        chk("memWe", 32'(memWe), 32'(wr));
        if (wr) chk("memWdata", memWdata, e_wd);
      end
      chk("stall_req", 32'(stall), 1);
      reqc++;
      memAck = reqc > waits;
      memRdata = memAck ? rdat : $urandom;
      @(negedge clk);
    end
    chk("req_cycles", 32'(reqc), 32'(exp_reqc));
    if (tmo) exp_rd = 0;
    else if (!wr) exp_rd = e_ld;
    chk("done_readdata", readData, exp_rd);
    chk("done_buserror", 32'(busError), 32'(tmo));
    chk("done_stall", 32'(stall), 0);
    memRead = 0; memWrite = 0; memAck = 1'($urandom); memRdata = $urandom;
    @(negedge clk);
    chk("idle_buserror", 32'(busError), 0);
    chk("idle_memreq", 32'(memReq), 0);
    chk("idle_readdata", readData, exp_rd);
    memAck = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic rd, wr;
    repeat (2) @(negedge clk);
    chk("rst_memReq", 32'(memReq), 0);
    chk("rst_memBe", 32'(memBe), 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_readData", readData, 0);
    chk("rst_stall", 32'(stall), 0);
    resetN = 1;
    access(0, 1, 3'd0, 2'd0, 32'h1003, 32'h000000AB, 32'h0, 2);
    chk("sb_lit_wdata", memWdata, 32'hABABABAB);
    access(1, 0, 3'd0, 2'd0, 32'h2001, 32'h0, 32'h12348056, 0);
    chk("lb_lit", readData, 32'hFFFFFF80);
    access(1, 0, 3'd3, 2'd0, 32'h2001, 32'h0, 32'h12348056, 0);
    chk("lbu_lit", readData, 32'h00000080);
    access(1, 0, 3'd1, 2'd0, 32'h2002, 32'h0, 32'h9ABC0000, 1);
    chk("lh_lit", readData, 32'hFFFF9ABC);
    access(1, 0, 3'd4, 2'd0, 32'h2002, 32'h0, 32'h9ABC0000, 0);
    chk("lhu_lit", readData, 32'h00009ABC);
    access(1, 0, 3'd2, 2'd0, 32'h2000, 32'h0, 32'h9ABC0000, 0);
    chk("lw_lit", readData, 32'h9ABC0000);
    access(1, 0, 3'd2, 2'd0, 32'h3002, 32'h0, 32'h0, 0);
    access(0, 1, 3'd0, 2'd1, 32'h3001, 32'h1234, 32'h0, 0);
    access(1, 1, 3'd2, 2'd1, 32'h3006, 32'hCAFEF00D, 32'h11111111, 1);
    access(1, 0, 3'd2, 2'd0, 32'h2000, 32'h0, 32'h55555555, 10);
    chk("tmo_lit", readData, 32'h0);
    @(negedge clk);
    memWrite = 1; storeSrc = 2'd2; addr = 32'h5000; writeData = 32'h77;
    @(negedge clk);
    chk("pre_rst_memReq", 32'(memReq), 1);
    #2 resetN = 0;
    #1;
    chk("async_rst_memReq", 32'(memReq), 0);
    chk("async_rst_stall", 32'(stall), 0);
    memWrite = 0;
    exp_rd = 0;
    @(negedge clk);
    resetN = 1;
    chk("post_rst_readData", readData, 0);
    access(0, 1, 3'd0, 2'd2, 32'h4000, 32'hDEADBEEF, 32'h0, 0);
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1;
      access(rd, wr, 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 5)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
